// File: rtl/pipelined_addsub_nbit_if.sv
// Stream interface for pipelined_addsub_nbit.
//   in_valid/in_ready  : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready: result beat handshake (s, cout, ovf)
// master modport: the side that produces operands and consumes results.
// slave modport : the adder/subtractor itself.
`timescale 1ns/1ps
interface pipelined_addsub_nbit_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_addsub_nbit.sv
// Pipelined N-bit adder/subtractor with carry-in, carry-out and signed
// overflow. The carry chain is cut into STAGES chunks of W = N/STAGES bits;
// stage k adds chunk k using the carry registered by stage k-1. Fixed latency
// of STAGES cycles, one beat per cycle, whole-pipe freeze on backpressure.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears valids and all data)
//   bus : slave side of pipelined_addsub_nbit_if
//         in_valid/in_ready, a, b, cin, sub     -> operand beat
//         out_valid/out_ready, s, cout, ovf     <- result beat
//         sub=0: {cout,s} = a + b + cin
//         sub=1: {cout,s} = a + ~b + ~cin  (cout=0 means borrow)
`timescale 1ns/1ps
module pipelined_addsub_nbit #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_addsub_nbit_if.slave bus
);

  localparam int W    = N / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage registers. The operand words travel whole, but only chunks above
  // a stage's index are consumed downstream; result chunks fill in from the
  // bottom as the beat moves up the pipe.
  logic [N-1:0] ar [STAGES];
  logic [N-1:0] br [STAGES];
  logic [N-1:0] sr [STAGES];
  logic         cr [STAGES];
  logic         vr [STAGES];
  logic         ovf_r;

  // Per-stage inputs and next values.
  logic [N-1:0] a_in [STAGES];
  logic [N-1:0] b_in [STAGES];
  logic [N-1:0] s_in [STAGES];
  logic         c_in [STAGES];
  logic         v_in [STAGES];
  logic [W:0]   csum [STAGES];
  logic [N-1:0] s_nx [STAGES];
  logic         ovf_nx;
  logic         stall;

  assign stall        = vr[LAST] && !bus.out_ready;
  assign bus.in_ready = !stall;

  always_comb begin
    // Stage 0 sees the raw beat with B and the carry inverted for subtract.
    a_in[0] = bus.a;
    b_in[0] = bus.b ^ {N{bus.sub}};
    s_in[0] = '0;
    c_in[0] = bus.cin ^ bus.sub;
    v_in[0] = bus.in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_in[k] = ar[k-1];
      b_in[k] = br[k-1];
      s_in[k] = sr[k-1];
      c_in[k] = cr[k-1];
      v_in[k] = vr[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      csum[k] = {1'b0, a_in[k][k*W +: W]} + {1'b0, b_in[k][k*W +: W]}
              + {{W{1'b0}}, c_in[k]};
      s_nx[k] = s_in[k];
      s_nx[k][k*W +: W] = csum[k][W-1:0];
    end
    ovf_nx = (a_in[LAST][N-1] == b_in[LAST][N-1]) &&
             (s_nx[LAST][N-1] != a_in[LAST][N-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ar[k] <= '0;
        br[k] <= '0;
        sr[k] <= '0;
        cr[k] <= 1'b0;
        vr[k] <= 1'b0;
      end
      ovf_r <= 1'b0;
    end else if (!stall) begin
      // Bubbles advance with the rest; the pipe only ever moves as a whole.
      for (int unsigned k = 0; k < STAGES; k++) begin
        ar[k] <= a_in[k];
        br[k] <= b_in[k];
        sr[k] <= s_nx[k];
        cr[k] <= csum[k][W];
        vr[k] <= v_in[k];
      end
      ovf_r <= ovf_nx;
    end
  end

  assign bus.out_valid = vr[LAST];
  assign bus.s         = sr[LAST];
  assign bus.cout      = cr[LAST];
  assign bus.ovf       = ovf_r;

endmodule
